// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC redirect / fetch sequencing controller:
// FSM states, redirect-source codes and the redirect priority function.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } state_t;

  localparam logic [1:0] REDIR_SEQ  = 2'b00;
  localparam logic [1:0] REDIR_JAL  = 2'b01;
  localparam logic [1:0] REDIR_JALR = 2'b10;
  localparam logic [1:0] REDIR_BR   = 2'b11;

  // EX-stage redirects are older than ID-stage ones, so they win.
  function automatic logic [1:0] redir_code(input logic branch, input logic jalr,
                                            input logic jal);
    if (branch)    return REDIR_BR;
    else if (jalr) return REDIR_JALR;
    else if (jal)  return REDIR_JAL;
    else           return REDIR_SEQ;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction across a decode stall.
module fetch_skid_buf #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [INST_W-1:0] din,
  output logic              valid,
  output logic [INST_W-1:0] dout
);

  logic              valid_q;
  logic [INST_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)                 valid_q <= 1'b0;
    else if (clear || unload) valid_q <= 1'b0;
    else if (load)           valid_q <= 1'b1;
  end

  // NOTE: the data register has no reset; it is only ever observed when valid_q is set.
  always_ff @(posedge clk) begin
    if (load) data_q <= din;
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC-enable / fetch-handshake / flush controller for the IF stage.
// Optional perf counters are enabled with `define PC_CTRL_PERF_EN.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int INST_W = 32
`ifdef PC_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              JalD,
  input  logic              JalrE,
  input  logic              BranchE,
  input  logic              StallD,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              imem_req_valid,
  output logic              pc_en,
  output logic [1:0]        redirect_src,
  output logic              if_id_we,
  output logic [INST_W-1:0] inst_IF,
  output logic              flush_ID,
  output logic              flush_EX
`ifdef PC_CTRL_PERF_EN
  , output logic [PERF_W-1:0] perf_stall_cnt
  , output logic [PERF_W-1:0] perf_redir_cnt
`endif
);

  state_t            state, state_n;
  logic              redir;
  logic              hold_valid;
  logic [INST_W-1:0] hold_data;
  logic              buf_load, buf_unload, buf_clear;

  fetch_skid_buf #(.INST_W(INST_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .unload (buf_unload),
    .clear  (buf_clear),
    .din    (imem_rsp_data),
    .valid  (hold_valid),
    .dout   (hold_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_n;
  end

  // NOTE: every signal is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    redir          = BranchE | JalrE | (JalD & ~StallD);
    state_n        = state;
    imem_req_valid = 1'b0;
    pc_en          = 1'b0;
    redirect_src   = REDIR_SEQ;
    if_id_we       = 1'b0;
    inst_IF        = '0;
    flush_ID       = 1'b0;
    flush_EX       = 1'b0;
    buf_load       = 1'b0;
    buf_unload     = 1'b0;
    buf_clear      = 1'b0;

    if (!rst) begin
      // Request depends only on registered state and redirect inputs, never on imem_rsp.
      imem_req_valid = (state == REQ) & ~hold_valid & ~redir;

      if (redir) begin
        pc_en        = 1'b1;
        redirect_src = redir_code(BranchE, JalrE, JalD);
        flush_ID     = 1'b1;
        flush_EX     = BranchE | JalrE;
        buf_clear    = 1'b1;
        case (state)
          WAIT:    state_n = imem_rsp_valid ? REQ : KILL;
          KILL:    if (imem_rsp_valid) state_n = REQ;
          default: state_n = state;
        endcase
      end else begin
        flush_EX = StallD;
        case (state)
          REQ: begin
            if (hold_valid && !StallD) begin
              if_id_we   = 1'b1;
              inst_IF    = hold_data;
              pc_en      = 1'b1;
              buf_unload = 1'b1;
            end
            if (imem_req_valid && imem_req_ready) state_n = WAIT;
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              state_n = REQ;
              if (StallD) begin
                buf_load = 1'b1;
              end else begin
                if_id_we = 1'b1;
                inst_IF  = imem_rsp_data;
                pc_en    = 1'b1;
              end
            end
          end
          KILL:    if (imem_rsp_valid) state_n = REQ;
          default: state_n = REQ;
        endcase
      end
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= stall_q + PERF_W'(~pc_en);
      redir_q <= redir_q + PERF_W'(redir);
    end
  end

  assign perf_stall_cnt = rst ? '0 : stall_q;
  assign perf_redir_cnt = rst ? '0 : redir_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        JalD, JalrE, BranchE, StallD;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, pc_en, if_id_we, flush_ID, flush_EX;
  logic [1:0]  redirect_src;
  logic [31:0] inst_IF;
`ifdef PC_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redir_cnt;
`endif

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.INST_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .JalD           (JalD),
    .JalrE          (JalrE),
    .BranchE        (BranchE),
    .StallD         (StallD),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_req_valid (imem_req_valid),
    .pc_en          (pc_en),
    .redirect_src   (redirect_src),
    .if_id_we       (if_id_we),
    .inst_IF        (inst_IF),
    .flush_ID       (flush_ID),
    .flush_EX       (flush_EX)
`ifdef PC_CTRL_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt)
    , .perf_redir_cnt (perf_redir_cnt)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: one outstanding fetch, whether it is wrong-path, and held instructions.
  bit          m_out;
  bit          m_wrong;
  logic [31:0] m_held[$];
  logic [31:0] m_stall_cnt, m_redir_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic br, input logic jalr, input logic jal, input logic stall,
                        input logic ready, input logic rsp, input logic [31:0] data);
    BranchE = br; JalrE = jalr; JalD = jal; StallD = stall;
    imem_req_ready = ready; imem_rsp_valid = rsp; imem_rsp_data = data;
  endtask

  // Compare one cycle's outputs mid-cycle, then advance the model across the clock edge.
  task automatic tick(input string tag);
    logic        e_redir, e_req, e_pc, e_we, e_fid, e_fex;
    logic [1:0]  e_src;
    logic [31:0] e_inst;
    #2;
    e_redir = BranchE | JalrE | (JalD & ~StallD);
    e_req = 0; e_pc = 0; e_we = 0; e_fid = 0; e_fex = 0; e_src = 2'd0; e_inst = 32'd0;
    if (!rst) begin
      e_req = !m_out && (m_held.size() == 0) && !e_redir;
      if (e_redir) begin
        e_pc  = 1;
        e_fid = 1;
        e_fex = BranchE | JalrE;
        e_src = BranchE ? 2'd3 : (JalrE ? 2'd2 : 2'd1);
      end else begin
        e_fex = StallD;
        if (m_out && !m_wrong && imem_rsp_valid && !StallD) begin
          e_we = 1; e_pc = 1; e_inst = imem_rsp_data;
        end else if (m_held.size() > 0 && !StallD) begin
          e_we = 1; e_pc = 1; e_inst = m_held[0];
        end
      end
    end
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(e_req));
    chk({tag, ".pc_en"},     32'(pc_en),          32'(e_pc));
    chk({tag, ".src"},       32'(redirect_src),   32'(e_src));
    chk({tag, ".if_id_we"},  32'(if_id_we),       32'(e_we));
    chk({tag, ".flush_ID"},  32'(flush_ID),       32'(e_fid));
    chk({tag, ".flush_EX"},  32'(flush_EX),       32'(e_fex));
    if (e_we || rst) chk({tag, ".inst_IF"}, inst_IF, e_inst);
`ifdef PC_CTRL_PERF_EN
    chk({tag, ".perf_stall"}, perf_stall_cnt, rst ? 32'd0 : m_stall_cnt);
    chk({tag, ".perf_redir"}, perf_redir_cnt, rst ? 32'd0 : m_redir_cnt);
`endif
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_wrong = 0; m_held.delete();
      m_stall_cnt = 0; m_redir_cnt = 0;
    end else begin
      m_stall_cnt += 32'(!e_pc);
      m_redir_cnt += 32'(e_redir);
      if (e_redir) begin
        m_held.delete();
        if (m_out) begin
          if (imem_rsp_valid) begin m_out = 0; m_wrong = 0; end
          else m_wrong = 1;
        end
      end else begin
        if (m_out && imem_rsp_valid) begin
          if (!m_wrong && StallD) m_held.push_back(imem_rsp_data);
          m_out = 0; m_wrong = 0;
        end else if (m_held.size() > 0 && !StallD) begin
          void'(m_held.pop_front());
        end
        if (e_req && imem_req_ready) m_out = 1;
      end
    end
    #1;
  endtask

  initial begin
    m_out = 0; m_wrong = 0; m_stall_cnt = 0; m_redir_cnt = 0;
    rst = 1;
    set_in(0, 0, 0, 0, 1, 0, 32'd0);
    tick("reset0");
    tick("reset1");
    rst = 0;

    // 1. Straight-line fetch, response two cycles after each request.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 0, 32'd0);          tick("t1_req");
      set_in(0, 0, 0, 0, 1, 0, 32'd0);          tick("t1_wait");
      set_in(0, 0, 0, 0, 1, 1, 32'h0000_0013);  tick("t1_rsp");
    end

    // 2. Branch in WAIT, wrong-path response the next cycle.
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t2_req");
    set_in(1, 0, 0, 0, 1, 0, 32'd0);            tick("t2_branch");
    set_in(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);    tick("t2_kill");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t2_reissue");
    set_in(0, 0, 0, 0, 1, 1, 32'h0000_0013);    tick("t2_rsp");

    // 3. Load-use stall for three cycles, response in the first.
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t3_req");
    set_in(0, 0, 0, 1, 1, 1, 32'h00A0_0093);    tick("t3_stall1");
    set_in(0, 0, 0, 1, 1, 0, 32'd0);            tick("t3_stall2");
    set_in(0, 0, 0, 1, 1, 0, 32'd0);            tick("t3_stall3");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t3_release");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t3_next_req");

    // 4. Simultaneous JAL/JALR, then JAL under a stall.
    set_in(0, 1, 1, 0, 1, 0, 32'd0);            tick("t4_jal_jalr");
    set_in(0, 0, 1, 1, 1, 1, 32'h1234_5678);    tick("t4_jal_stalled");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t4_after");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t4_drain");

    // 5. Redirect and response in the same WAIT cycle.
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t5_req");
    set_in(0, 0, 1, 0, 1, 1, 32'hCAFE_F00D);    tick("t5_jal_rsp");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t5_reissue");

    // 6. Reset mid-fetch, stale response afterwards.
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t6_wait");
    rst = 1;
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t6_rst0");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t6_rst1");
    rst = 0;
    set_in(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);    tick("t6_stale");
    set_in(0, 0, 0, 0, 1, 0, 32'd0);            tick("t6_req");

    // Random traffic respecting the single-outstanding protocol, with rare stray responses.
    for (int i = 0; i < 800; i++) begin
      logic rsp;
      rst = ($urandom_range(0, 149) == 0);
      rsp = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, rsp, $urandom);
      tick("rand");
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
